// File: rtl/led_scan_mux.sv
// Time-multiplexed digit scanner feeding the BCD-to-7-segment decoder and common-anode enables.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module led_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV_WIDTH    = 16,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [4*NUM_DIGITS-1:0]         digits_bcd,
    input  logic [NUM_DIGITS-1:0]           digit_mask,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    output logic [3:0]                      bcd,
    output logic [NUM_DIGITS-1:0]           dig_sel,
    output logic                            dp,
    output logic [$clog2(NUM_DIGITS)-1:0]   scan_idx,
    output logic                            frame_tick
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [DIV_WIDTH-1:0] CNT_LAST  = DIV_WIDTH'(SCAN_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] CNT_BLANK = DIV_WIDTH'(BLANK_CYCLES);
    localparam logic [IW-1:0]        IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [DIV_WIDTH-1:0]            cnt_q, cnt_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic                            active_q;
    logic                            load;
    logic [NUM_DIGITS-1:0][3:0]      digits_q, digits_d;
    logic [NUM_DIGITS-1:0]           mask_q, mask_d;
    logic [NUM_DIGITS-1:0]           dpm_q, dpm_d;
    logic [3:0]                      bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]           dig_sel_q, dig_sel_d;
    logic                            dp_q, dp_d;
    logic                            tick_q;
    logic                            lit;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]           lz_q, lz_d, lz_next;
    logic                            zero_run;
`endif

    // The first enabled cycle restarts the scan and loads a frame; later loads happen only at frame wrap.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        load  = 1'b0;
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (!active_q) begin
            cnt_d = '0;
            idx_d = '0;
            load  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                load  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        digits_d = load ? digits_bcd : digits_q;
        mask_d   = load ? digit_mask : mask_q;
        dpm_d    = load ? dp_in      : dpm_q;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher digit of the incoming frame are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_next  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (digits_bcd[4*i +: 4] == 4'h0);
            lz_next[i] = zero_run;
        end
        lz_next[0] = 1'b0;
        lz_d = load ? lz_next : lz_q;
    end
`endif

    // Outputs are computed from next-state so the registered value lines up with the counter.
    always_comb begin
        state_d = (en && (cnt_d >= CNT_BLANK)) ? DRIVE : BLANK;
`ifdef LEADING_ZERO_BLANK_EN
        lit = (state_d == DRIVE) && mask_d[idx_d] && !lz_d[idx_d];
`else
        lit = (state_d == DRIVE) && mask_d[idx_d];
`endif
        bcd_d     = lit ? digits_d[idx_d] : 4'hF;
        dig_sel_d = lit ? ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d) : '1;
        dp_d      = lit ? ~dpm_d[idx_d] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= 1'b0;
            digits_q  <= '0;
            mask_q    <= '0;
            dpm_q     <= '0;
            bcd_q     <= 4'hF;
            dig_sel_q <= '1;
            dp_q      <= 1'b1;
            tick_q    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            lz_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= en;
            digits_q  <= digits_d;
            mask_q    <= mask_d;
            dpm_q     <= dpm_d;
            bcd_q     <= bcd_d;
            dig_sel_q <= dig_sel_d;
            dp_q      <= dp_d;
            tick_q    <= load;
`ifdef LEADING_ZERO_BLANK_EN
            lz_q      <= lz_d;
`endif
        end
    end

    assign bcd        = bcd_q;
    assign dig_sel    = dig_sel_q;
    assign dp         = dp_q;
    assign scan_idx   = idx_q;
    assign frame_tick = tick_q;

endmodule
